// File: rtl/block_ram_arbiter.sv
// Round-robin arbiter sharing one single-port, read-first block RAM between
// an instruction-fetch port (0) and a load/store port (1).
module block_ram_arbiter #(
    parameter int W = 8,
    parameter int L = 32,
    localparam int AW = $clog2(L)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic          wr_ena0,
    input  logic [W-1:0]  wr_data0,
    output logic          ack0,
    output logic [W-1:0]  rd_data0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic          wr_ena1,
    input  logic [W-1:0]  wr_data1,
    output logic          ack1,
    output logic [W-1:0]  rd_data1,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_ena,
    output logic [W-1:0]  mem_wr_data,
    input  logic [W-1:0]  mem_rd_data,
    output logic          busy
);

    // Handshake: a port holds req and its address/data stable until it sees a
    // one-cycle ack; while ack is high that port is ignored so it is not served twice.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        state;
    logic          grant;
    logic          prio;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [W-1:0]  wdata_q;

    logic elig0;
    logic elig1;
    logic win;

    assign elig0 = req0 && !ack0;
    assign elig1 = req1 && !ack1;

    always_comb begin
        win = elig1;
        if (elig0 && elig1) begin
            win = prio;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= 1'b0;
            prio     <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rd_data0 <= '0;
            rd_data1 <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (elig0 || elig1) begin
                        grant   <= win;
                        prio    <= ~win;
                        addr_q  <= win ? addr1 : addr0;
                        we_q    <= win ? wr_ena1 : wr_ena0;
                        wdata_q <= win ? wr_data1 : wr_data0;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= RESP;
                end
                RESP: begin
                    // RAM output now reflects the row as it was before any write.
                    if (grant) begin
                        rd_data1 <= mem_rd_data;
                        ack1     <= 1'b1;
                    end else begin
                        rd_data0 <= mem_rd_data;
                        ack0     <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr    = addr_q;
    assign mem_wr_data = wdata_q;
    // Reset kills an in-flight write in the same cycle it is asserted.
    assign mem_wr_ena  = (state == ISSUE) && we_q && !rst;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_block_ram_arbiter.sv
// Directed bench for block_ram_arbiter with a read-first single-port RAM model
// and immediate-assertion checks sampled 1 time unit after each rising edge.
module tb_block_ram_arbiter;

    localparam int W  = 8;
    localparam int L  = 32;
    localparam int AW = $clog2(L);

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, wr_ena0, ack0;
    logic [AW-1:0] addr0;
    logic [W-1:0]  wr_data0, rd_data0;
    logic          req1, wr_ena1, ack1;
    logic [AW-1:0] addr1;
    logic [W-1:0]  wr_data1, rd_data1;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_ena;
    logic [W-1:0]  mem_wr_data;
    logic [W-1:0]  mem_rd_data;
    logic          busy;

    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [W-1:0]  pl_data;
    logic [W-1:0]  ram [L] = '{default: '0};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    block_ram_arbiter #(.W(W), .L(L)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .wr_ena0(wr_ena0), .wr_data0(wr_data0),
        .ack0(ack0), .rd_data0(rd_data0),
        .req1(req1), .addr1(addr1), .wr_ena1(wr_ena1), .wr_data1(wr_data1),
        .ack1(ack1), .rd_data1(rd_data1),
        .mem_addr(mem_addr), .mem_wr_ena(mem_wr_ena), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .busy(busy)
    );

    // Read-first single-port RAM with a bench-side preload path.
    always @(posedge clk) begin
        mem_rd_data <= ram[mem_addr];
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (mem_wr_ena) begin
            ram[mem_addr] <= mem_wr_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic wait3();
        tick();
        tick();
        tick();
    endtask

    logic exp_a0, exp_a1;

    initial begin
        rst = 1'b1;
        req0 = 1'b0; addr0 = '0; wr_ena0 = 1'b0; wr_data0 = '0;
        req1 = 1'b0; addr1 = '0; wr_ena1 = 1'b0; wr_data1 = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;

        preload(5'd3, 8'h5A);
        preload(5'd9, 8'h96);
        preload(5'd5, 8'hA5);
        preload(5'd2, 8'h11);
        preload(5'd4, 8'h00);
        preload(5'd7, 8'hFF);

        // Reset held for two cycles with both ports requesting.
        req0 = 1'b1; addr0 = 5'd3;
        req1 = 1'b1; addr1 = 5'd9;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_ack0", ack0, 0);
            check("rst_ack1", ack1, 0);
            check("rst_rd0", rd_data0, 0);
            check("rst_rd1", rd_data1, 0);
            check("rst_busy", busy, 0);
            check("rst_wena", mem_wr_ena, 0);
        end
        rst = 1'b0;
        tick();
        check("rel_busy", busy, 1);
        check("rel_first_p0", mem_addr, 3);
        tick();
        tick();
        check("rel_ack0", ack0, 1);
        check("rel_ack1_lo", ack1, 0);
        check("rel_rd0", rd_data0, 8'h5A);
        req0 = 1'b0;
        wait3();
        check("rel_ack1", ack1, 1);
        check("rel_rd1", rd_data1, 8'h96);
        req1 = 1'b0;
        tick();

        // Single read of row 5.
        req0 = 1'b1; addr0 = 5'd5; wr_ena0 = 1'b0;
        tick();
        check("rd_maddr", mem_addr, 5);
        check("rd_busy1", busy, 1);
        check("rd_wena", mem_wr_ena, 0);
        check("rd_ack0_c1", ack0, 0);
        tick();
        check("rd_ack0_c2", ack0, 0);
        check("rd_busy2", busy, 1);
        tick();
        check("rd_ack0_c3", ack0, 1);
        check("rd_data0", rd_data0, 8'hA5);
        check("rd_busy3", busy, 0);
        req0 = 1'b0;
        tick();
        check("rd_ack0_c4", ack0, 0);
        check("rd_hold", rd_data0, 8'hA5);
        check("rd_idle", busy, 0);

        // Port 1 writes 0x3C to row 7, then port 0 reads it back.
        req1 = 1'b1; addr1 = 5'd7; wr_ena1 = 1'b1; wr_data1 = 8'h3C;
        tick();
        check("wr_wena_c1", mem_wr_ena, 1);
        check("wr_maddr", mem_addr, 7);
        check("wr_mdata", mem_wr_data, 8'h3C);
        tick();
        check("wr_wena_c2", mem_wr_ena, 0);
        tick();
        check("wr_ack1", ack1, 1);
        check("wr_old7", rd_data1, 8'hFF);
        req1 = 1'b0; wr_ena1 = 1'b0;
        req0 = 1'b1; addr0 = 5'd7;
        wait3();
        check("wr_rb_ack0", ack0, 1);
        check("wr_rb_data", rd_data0, 8'h3C);
        req0 = 1'b0;
        tick();

        // Read-first write on row 2.
        req1 = 1'b1; addr1 = 5'd2; wr_ena1 = 1'b1; wr_data1 = 8'h22;
        wait3();
        check("rf_ack1", ack1, 1);
        check("rf_old", rd_data1, 8'h11);
        req1 = 1'b0; wr_ena1 = 1'b0;
        req0 = 1'b1; addr0 = 5'd2;
        wait3();
        check("rf_ack0", ack0, 1);
        check("rf_new", rd_data0, 8'h22);
        req0 = 1'b0;
        tick();

        // Port 1 read alone so port 0 holds priority going into contention.
        req1 = 1'b1; addr1 = 5'd7;
        wait3();
        check("p1_ack1", ack1, 1);
        check("p1_rd", rd_data1, 8'h3C);
        req1 = 1'b0;
        tick();

        // Contention: both ports request continuously; grants must alternate.
        req0 = 1'b1; addr0 = 5'd5;
        req1 = 1'b1; addr1 = 5'd2;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_a0 = (k == 3) || (k == 9);
            exp_a1 = (k == 6) || (k == 12);
            check($sformatf("ct_ack0_c%0d", k), ack0, exp_a0);
            check($sformatf("ct_ack1_c%0d", k), ack1, exp_a1);
            if (k == 3) begin
                check("ct_rd0_c3", rd_data0, 8'hA5);
                addr0 = 5'd7;
            end
            if (k == 6) begin
                check("ct_rd1_c6", rd_data1, 8'h22);
                addr1 = 5'd9;
            end
            if (k == 9) check("ct_rd0_c9", rd_data0, 8'h3C);
            if (k == 12) check("ct_rd1_c12", rd_data1, 8'h96);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        tick();
        check("ct_idle", busy, 0);

        // Reset asserted during the ISSUE cycle of a write.
        req1 = 1'b1; addr1 = 5'd4; wr_ena1 = 1'b1; wr_data1 = 8'h77;
        tick();
        check("rm_wena_pre", mem_wr_ena, 1);
        rst = 1'b1;
        #1;
        check("rm_wena_rst", mem_wr_ena, 0);
        tick();
        check("rm_ack1", ack1, 0);
        check("rm_busy", busy, 0);
        check("rm_rd1", rd_data1, 0);
        check("rm_row4", ram[4], 8'h00);
        rst = 1'b0;
        tick();
        check("rm_retry_wena", mem_wr_ena, 1);
        check("rm_retry_ack_c1", ack1, 0);
        tick();
        check("rm_retry_ack_c2", ack1, 0);
        tick();
        check("rm_retry_ack", ack1, 1);
        check("rm_retry_old", rd_data1, 8'h00);
        check("rm_row4_new", ram[4], 8'h77);
        req1 = 1'b0; wr_ena1 = 1'b0;
        tick();
        check("rm_end_ack", ack1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/block_ram_arbiter.md
Name: block_ram_arbiter

Overview:
Two-port round-robin arbiter that shares one single-port block RAM (1-cycle registered read, read-first on write) between two requesters: port 0 is instruction fetch and port 1 is load/store in the RISC-V core. It sequences each granted access through a fixed 3-state FSM. It returns read data and a one-cycle acknowledge to the winning port. It is the sole driver of the RAM's addr, wr_ena and wr_data.

Parameters:
W, 8, data width of each RAM row and of all data ports
L, 32, RAM depth in rows; address width AW = $clog2(L)

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  synchronous, active-high reset
req0  input  1  port 0 request; held high with addr0/wr_ena0/wr_data0 stable until ack0
addr0  input  AW  port 0 row address
wr_ena0  input  1  port 0 write (1) / read (0)
wr_data0  input  W  port 0 write data
ack0  output  1  one-cycle completion pulse for port 0
rd_data0  output  W  port 0 read data, valid when ack0=1, held until next ack0
req1, addr1, wr_ena1, wr_data1, ack1, rd_data1  same as port 0, for port 1
mem_addr  output  AW  to RAM addr
mem_wr_ena  output  1  to RAM wr_ena
mem_wr_data  output  W  to RAM wr_data
mem_rd_data  input  W  from RAM rd_data (valid the cycle after address is presented)
busy  output  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE, ISSUE, RESP. Registers: state, grant (1 bit), prio (1 bit), addr_q, we_q, wdata_q, ack0/ack1, rd_data0/rd_data1.
- Reset (sync, rst=1 at posedge): state=IDLE, prio=0, grant=0, ack0=ack1=0, rd_data0=rd_data1=0, addr_q=0, we_q=0, wdata_q=0. mem_wr_ena is combinationally forced to 0 whenever rst=1, which suppresses any in-flight write. The in-flight access is dropped with no ack. A requester still holding req is re-served after reset deasserts.
- Eligibility in IDLE: portN is eligible iff reqN=1 and ackN=0. This prevents a duplicate access in the cycle the requester sees ack.
- IDLE, nothing eligible: stay IDLE.
- IDLE, one eligible: grant it. Both eligible: grant port prio.
- On grant: latch addr/wr_ena/wr_data of the winner into addr_q/we_q/wdata_q, set grant, set prio = ~winner, go to ISSUE.
- ISSUE (exactly 1 cycle): mem_addr=addr_q and mem_wr_ena=we_q; the RAM reads and, if enabled, writes at the end-of-cycle edge. Next state is RESP.
- RESP (exactly 1 cycle): mem_rd_data is valid. At the edge: rd_data[grant] <= mem_rd_data, ack[grant] <= 1, state -> IDLE.
- ack0/ack1 are high for exactly one cycle, the cycle after RESP. They are never both high.
- mem_addr = addr_q and mem_wr_data = wdata_q at all times. mem_wr_ena = we_q when state=ISSUE and rst=0, else 0.
- Writes also ack. Their rd_data captures the row's old contents (RAM is read-first).
- Latency: req seen in IDLE at cycle 0 -> ack in cycle 3. Peak throughput is 1 access per 3 cycles.
- With both ports continuously re-requesting, grants strictly alternate. Neither port waits more than one other access.
- Changing req/addr/data while waiting and before ack is a protocol violation. Behaviour is defined only by the values latched at grant.
- Address is used modulo row count. An out-of-range address (>= L when L is not a power of 2) is undefined.

Test Plan:
- Reset: assert rst 2 cycles with req0=req1=1 -> ack0=ack1=0, rd_data0=rd_data1=0, busy=0, mem_wr_ena=0 throughout. The first grant after release goes to port 0.
- Single read: RAM preloaded with row 5 = 0xA5; req0=1, addr0=5, wr_ena0=0 at cycle 0 -> mem_addr=5 in cycle 1, ack0=1 with rd_data0=0xA5 in cycle 3 only. Exactly one RAM access occurs, and rd_data0 holds 0xA5 afterwards.
- Write then read: port 1 writes 0x3C to addr 7 (ack1 at cycle 3, mem_wr_ena high only in cycle 1); then port 0 reads addr 7 -> rd_data0=0x3C.
- Read-first write: row 2 = 0x11; port 1 writes 0x22 to addr 2 -> ack1 with rd_data1=0x11. A following read of addr 2 returns 0x22.
- Contention: both ports request from cycle 0 and re-request immediately after each ack -> acks occur at cycles 3(p0), 6(p1), 9(p0), 12(p1). No back-to-back grants to the same port, and no duplicate access while ack is high.
- Reset mid-op: port 1 writes 0x77 to addr 4 (row 4 = 0x00); assert rst during ISSUE -> mem_wr_ena=0 that cycle, no ack1, row 4 stays 0x00. After release with req1 still held, the write completes 3 cycles later.
